// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sp_ram_pkg
// Brief    : Shared widths, types and FSM encoding for the RAM read engine.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package sp_ram_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 16;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ADDR_W:0]   len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sync_fifo
// Brief    : Small single-clock FIFO; empty head reads as zero.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_last_idx) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sp_ram_reader
// Brief    : Sequential-address read engine streaming RAM words over valid/ready.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sp_ram_reader
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 2
)(
    input  logic              wclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int              CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] c_ram_depth  = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [CNT_W:0]  c_fifo_depth = (CNT_W + 1)'(FIFO_DEPTH);

    rd_state_e         r_state;
    rd_state_e         w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   w_remaining_next;
    logic [ADDR_W:0]   w_len_eff;
    logic              r_in_flight;
    logic              r_in_last;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_room;
    logic              w_pop;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W:0]   w_head;

    assign w_len_eff = (len > c_ram_depth) ? c_ram_depth : len;
    assign w_pop     = m_valid && m_ready;
    // Count the word still in the RAM pipeline so the FIFO can never overflow.
    assign w_room    = !(w_fifo_full && !w_pop) &&
                       (({1'b0, w_fifo_count} + (CNT_W + 1)'(r_in_flight)
                         - (CNT_W + 1)'(w_pop)) < c_fifo_depth);

    always_comb begin
        w_next_state     = r_state;
        w_issue          = 1'b0;
        w_issue_addr     = r_addr;
        w_issue_last     = 1'b0;
        w_remaining_next = r_remaining;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_eff == '0) begin
                        w_next_state = DONE;
                    end else begin
                        w_issue          = 1'b1;
                        w_issue_addr     = start_addr;
                        w_issue_last     = (w_len_eff == (ADDR_W + 1)'(1));
                        w_remaining_next = w_len_eff - 1'b1;
                        w_next_state     = RUN;
                    end
                end
            end
            RUN: begin
                if (r_remaining == '0) begin
                    w_next_state = DRAIN;
                end else if (w_room) begin
                    w_issue          = 1'b1;
                    w_issue_addr     = r_addr + 1'b1;
                    w_issue_last     = (r_remaining == (ADDR_W + 1)'(1));
                    w_remaining_next = r_remaining - 1'b1;
                end
            end
            DRAIN: begin
                if (w_pop && m_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_in_flight <= 1'b0;
            r_in_last   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_remaining_next;
            r_in_flight <= w_issue;
            r_in_last   <= w_issue_last;
            if (w_issue) begin
                r_addr <= w_issue_addr;
            end
        end
    end

    // The address is presented combinationally so the RAM samples it on the issue edge.
    assign ram_addr = w_issue_addr;
    assign ram_we   = 1'b0;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign m_valid  = !w_fifo_empty;
    assign m_data   = w_head[DATA_W-1:0];
    assign m_last   = w_head[DATA_W];

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (wclk),
        .rst_n       (rst_n),
        .i_push      (r_in_flight),
        .i_push_data ({r_in_last, ram_rd_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_sp_ram_reader
// Brief    : Directed bench for sp_ram_reader with a behavioural 8x16 RAM.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sp_ram_reader;
    import sp_ram_pkg::*;

    logic  wclk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    addr_t start_addr = '0;
    len_t  len = '0;
    logic  m_ready = 1'b0;
    logic  busy, done, ram_we, m_valid, m_last;
    addr_t ram_addr;
    data_t ram_rd_data, m_data;
    data_t ram_mem [8];

    int errors = 0;
    int checks = 0;

    always #5 wclk = ~wclk;

    sp_ram_reader #(.ADDR_W(3), .DATA_W(16), .FIFO_DEPTH(2)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last)
    );

    always @(posedge wclk) ram_rd_data <= ram_mem[ram_addr];

    // Per-cycle observation log, sampled mid-cycle.
    bit    mon_en = 1'b0;
    int    cyc, busy_cnt, done_cnt, done_cyc, first_valid_cyc, last_acc_cyc;
    int    stall_err, max_ahead, ahead, we_seen = 0;
    addr_t addr_log [64];
    data_t acc_data [$];
    logic  acc_last [$];
    bit    stall_prev;
    data_t prev_data;
    logic  prev_last;

    always @(negedge wclk) begin
        if (ram_we !== 1'b0) we_seen++;
        if (mon_en) begin
            if (cyc < 64) addr_log[cyc] = ram_addr;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_prev && (m_data !== prev_data || m_last !== prev_last)) stall_err++;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            ahead = int'(ram_addr) + 1 - (acc_data.size() + ((m_valid && m_ready) ? 1 : 0));
            if (ahead > max_ahead) max_ahead = ahead;
            if (m_valid && m_ready) begin
                acc_data.push_back(m_data);
                acc_last.push_back(m_last);
                last_acc_cyc = cyc;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic mon_clear();
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; last_acc_cyc = -1; stall_err = 0; max_ahead = 0;
        stall_prev = 1'b0;
        acc_data.delete();
        acc_last.delete();
        mon_en = 1'b1;
    endtask

    task automatic begin_run(input int sa, input int ln);
        mon_clear();
        start = 1'b1; start_addr = 3'(sa); len = 4'(ln);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        timed_out = (done_cnt == 0);
        tick();
        tick();
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, ram_addr, ram_we, m_valid, m_last, m_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%0d we=%b valid=%b last=%b data=%h want all 0",
                     busy, done, ram_addr, ram_we, m_valid, m_last, m_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        bit to; data_t exp_d; addr_t exp_a;
        m_ready = 1'b1;
        begin_run(0, 8);
        wait_done(40, to);
        checks++; if (to) begin errors++; $display("FAIL seq_timeout: got no done want done"); end
        checks++; if (acc_data.size() != 8) begin errors++; $display("FAIL seq_count: got %0d want 8", acc_data.size()); end
        for (int k = 0; k < 8 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * k);
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL seq_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 7));
            end
        end
        checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL seq_first_valid: got %0d want 2", first_valid_cyc); end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL seq_busy_span: got %0d want 10", busy_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != 10) begin errors++; $display("FAIL seq_done: got cnt=%0d cyc=%0d want 1/10", done_cnt, done_cyc); end
        checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL seq_done_after_last: got %0d want %0d", done_cyc, last_acc_cyc + 1); end
        for (int k = 0; k < cyc; k++) begin
            exp_a = 3'((k < 7) ? k : 7);
            checks++;
            if (addr_log[k] !== exp_a) begin errors++; $display("FAIL seq_addr_c%0d: got %0d want %0d", k, addr_log[k], exp_a); end
        end
    endtask

    task automatic test_wrap();
        bit to; data_t exp_d; addr_t exp_a;
        m_ready = 1'b1;
        begin_run(6, 4);
        wait_done(40, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout: got no done want done"); end
        checks++; if (acc_data.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", acc_data.size()); end
        for (int k = 0; k < 4 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * ((6 + k) % 8));
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 3));
            end
        end
        for (int k = 0; k < cyc; k++) begin
            exp_a = 3'(6 + ((k < 3) ? k : 3));
            checks++;
            if (addr_log[k] !== exp_a) begin errors++; $display("FAIL wrap_addr_c%0d: got %0d want %0d", k, addr_log[k], exp_a); end
        end
    endtask

    task automatic test_backpressure();
        data_t exp_d; int step;
        mon_clear();
        start = 1'b1; start_addr = 3'd0; len = 4'd5; m_ready = 1'b1;
        step = 0;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            tick();
            start = 1'b0;
            step++;
            m_ready = (step % 3 == 0);
        end
        m_ready = 1'b1;
        tick(); tick();
        mon_en = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
        checks++; if (acc_data.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", acc_data.size()); end
        for (int k = 0; k < 5 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * k);
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 4)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 4));
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_err); end
        checks++; if (max_ahead > 2) begin errors++; $display("FAIL bp_ahead: got %0d want <=2", max_ahead); end
        checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL bp_done_after_last: got %0d want %0d", done_cyc, last_acc_cyc + 1); end
    endtask

    task automatic test_len_edges();
        bit to; data_t exp_d;
        m_ready = 1'b1;
        begin_run(3, 0);
        wait_done(10, to);
        checks++; if (to || done_cyc != 1) begin errors++; $display("FAIL len0_done: got cyc=%0d want 1", done_cyc); end
        checks++; if (first_valid_cyc != -1) begin errors++; $display("FAIL len0_valid: got valid at %0d want never", first_valid_cyc); end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL len0_busy: got %0d want 1", busy_cnt); end
        for (int k = 0; k < cyc; k++) begin
            checks++;
            if (addr_log[k] !== 3'd4) begin errors++; $display("FAIL len0_addr_c%0d: got %0d want 4", k, addr_log[k]); end
        end
        begin_run(0, 12);
        wait_done(40, to);
        checks++; if (to || acc_data.size() != 8) begin errors++; $display("FAIL len12_count: got %0d want 8", acc_data.size()); end
        for (int k = 0; k < 8 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * k);
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL len12_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 7));
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit to; data_t exp_d; addr_t exp_a;
        m_ready = 1'b1;
        begin_run(0, 8);
        tick(); tick();
        start = 1'b1; start_addr = 3'd5; len = 4'd3;
        tick();
        start = 1'b0;
        wait_done(40, to);
        checks++; if (to || done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got %0d pulses want 1", done_cnt); end
        checks++; if (acc_data.size() != 8) begin errors++; $display("FAIL busy_start_count: got %0d want 8", acc_data.size()); end
        for (int k = 0; k < 8 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * k);
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL busy_start_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 7));
            end
        end
        for (int k = 0; k < cyc; k++) begin
            exp_a = 3'((k < 7) ? k : 7);
            checks++;
            if (addr_log[k] !== exp_a) begin errors++; $display("FAIL busy_start_addr_c%0d: got %0d want %0d", k, addr_log[k], exp_a); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit to; int valid_after; data_t exp_d;
        m_ready = 1'b1;
        begin_run(0, 8);
        tick(); tick(); tick(); tick();
        checks++;
        if (acc_data.size() != 3) begin errors++; $display("FAIL rst_mid_accepts: got %0d want 3", acc_data.size()); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, ram_addr, ram_we, m_valid, m_last, m_data} !== 24'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%b done=%b addr=%0d valid=%b last=%b data=%h want all 0",
                     busy, done, ram_addr, m_valid, m_last, m_data);
        end
        done_cnt = 0;
        valid_after = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_valid) valid_after++;
        end
        mon_en = 1'b0;
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt); end
        checks++; if (valid_after != 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d cycles want 0", valid_after); end
        begin_run(2, 3);
        wait_done(40, to);
        checks++; if (to || done_cnt != 1 || acc_data.size() != 3) begin
            errors++; $display("FAIL rst_rerun: got done=%0d words=%0d want 1/3", done_cnt, acc_data.size());
        end
        for (int k = 0; k < 3 && k < acc_data.size(); k++) begin
            exp_d = 16'(16'h1111 * (2 + k));
            checks++;
            if (acc_data[k] !== exp_d || acc_last[k] !== (k == 2)) begin
                errors++;
                $display("FAIL rst_rerun_word%0d: got %h last=%b want %h last=%b", k, acc_data[k], acc_last[k], exp_d, (k == 2));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram_mem[i] = 16'(16'h1111 * i);
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_len_edges();
        test_start_while_busy();
        test_reset_mid_run();
        checks++;
        if (we_seen != 0) begin errors++; $display("FAIL ram_we_zero: got %0d cycles high want 0", we_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
